// File: rtl/pkt_drain_fifo.sv
// Packet holding FIFO: buffers parser beats and releases one whole
// packet per allow_drain pulse, tagged with its action word.
module pkt_drain_fifo #(
   parameter int DATA_W    = 64,
   parameter int ACTION_W  = 64,
   parameter int DEPTH     = 64,
   parameter int ACT_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_sop,
   input  logic                in_eop,
   output logic                in_ready,
   input  logic                allow_drain,
   input  logic [ACTION_W-1:0] action_in,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_sop,
   output logic                out_eop,
   output logic [ACTION_W-1:0] out_action,
   input  logic                out_ready,
   output logic [15:0]         drop_count,
   output logic                err_act_ovf,
   output logic                err_framing
);

   localparam int AW = $clog2(DEPTH);
   localparam int QW = $clog2(ACT_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   logic [DATA_W+1:0]   mem [DEPTH];
   logic [AW:0]         wptr;
   logic [AW:0]         rptr;
   logic [ACTION_W-1:0] aq [ACT_DEPTH];
   logic [QW:0]         awptr;
   logic [QW:0]         arptr;
   logic [1:0]          state;
   logic [ACTION_W-1:0] cur_action;

   logic                data_empty;
   logic                data_full;
   logic                act_empty;
   logic                act_full;
   logic                push;
   logic                pop;
   logic                act_push;
   logic                act_pop;
   logic [DATA_W-1:0]   head_data;
   logic                head_sop;
   logic                head_eop;
   logic [ACTION_W-1:0] act_head;

   // MSB of each pointer tells a full queue from an empty one
   assign data_empty = (wptr == rptr);
   assign data_full  = (wptr[AW] != rptr[AW]) &&
                       (wptr[AW-1:0] == rptr[AW-1:0]);
   assign act_empty  = (awptr == arptr);
   assign act_full   = (awptr[QW] != arptr[QW]) &&
                       (awptr[QW-1:0] == arptr[QW-1:0]);

   assign in_ready = !data_full;
   assign push     = in_valid && in_ready;
   assign act_push = allow_drain && !act_full;

   assign {head_data, head_sop, head_eop} = mem[rptr[AW-1:0]];
   assign act_head = aq[arptr[QW-1:0]];

   always_comb begin
      pop       = 1'b0;
      act_pop   = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            act_pop = !act_empty && !data_empty;
         end
         DRAIN: begin
            out_valid = !data_empty;
            pop       = !data_empty && out_ready;
         end
         DROP: begin
            pop = !data_empty;
         end
         default: begin
         end
      endcase
   end

   assign out_data   = out_valid ? head_data : '0;
   assign out_sop    = out_valid && head_sop;
   assign out_eop    = out_valid && head_eop;
   assign out_action = cur_action;

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= {in_data, in_sop, in_eop};
   end

   always_ff @(posedge clk) begin
      if (act_push) aq[awptr[QW-1:0]] <= action_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         awptr       <= '0;
         arptr       <= '0;
         state       <= IDLE;
         cur_action  <= '0;
         drop_count  <= '0;
         err_act_ovf <= 1'b0;
         err_framing <= 1'b0;
      end else begin
         if (push)     wptr  <= wptr + (AW+1)'(1);
         if (pop)      rptr  <= rptr + (AW+1)'(1);
         if (act_push) awptr <= awptr + (QW+1)'(1);
         if (act_pop)  arptr <= arptr + (QW+1)'(1);
         if (allow_drain && act_full) err_act_ovf <= 1'b1;
         unique case (state)
            IDLE: begin
               if (act_pop) begin
                  cur_action <= act_head;
                  state      <= act_head[0] ? DROP : DRAIN;
                  // a headless beat is still taken as the packet start
                  if (!head_sop) err_framing <= 1'b1;
               end
            end
            DRAIN: begin
               if (pop && head_eop) state <= IDLE;
            end
            DROP: begin
               if (pop && head_eop) begin
                  state <= IDLE;
                  if (drop_count != 16'hFFFF)
                     drop_count <= drop_count + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_drain_fifo.sv
// Directed scoreboard bench for pkt_drain_fifo.
// Beats checked at negedge against an expected-beat queue.
module tb_pkt_drain_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_sop;
   logic        in_eop;
   logic        in_ready;
   logic        allow_drain;
   logic [63:0] action_in;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [63:0] out_action;
   logic        out_ready;
   logic [15:0] drop_count;
   logic        err_act_ovf;
   logic        err_framing;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] d;
      logic [1:0]  fl;
      logic [63:0] act;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pkt_drain_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_ready    (in_ready),
      .allow_drain (allow_drain),
      .action_in   (action_in),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_action  (out_action),
      .out_ready   (out_ready),
      .drop_count  (drop_count),
      .err_act_ovf (err_act_ovf),
      .err_framing (err_framing)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic neg;
      @(negedge clk);
   endtask

   task automatic push(input logic [63:0] d, input logic s,
                       input logic e, input logic en,
                       input logic [63:0] act);
      int n;
      exp_t x;
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      if (n == 300) chk("push_timeout", 64'(n), 64'd0);
      if (en) begin
         x.d = d;
         x.fl = {s, e};
         x.act = act;
         sb.push_back(x);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse(input logic [63:0] act);
      allow_drain = 1'b1;
      action_in   = act;
      tick();
      allow_drain = 1'b0;
   endtask

   task automatic wait_drain;
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, out_data, 64'd0);
      chk({tag, "_sop_eop"}, 64'({out_sop, out_eop}), 64'd0);
      chk({tag, "_out_action"}, out_action, 64'd0);
      chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
      chk({tag, "_errs"}, 64'({err_act_ovf, err_framing}), 64'd0);
   endtask

   // scoreboard monitor and stall-stability check
   logic [63:0] prev_d;
   logic        prev_stall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && prev_stall) begin
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", out_data, prev_d);
      end
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_sop_eop", 64'({out_sop, out_eop}), 64'(e.fl));
            chk("beat_action", out_action, e.act);
         end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_d     = out_data;
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_sop      = 1'b0;
      in_eop      = 1'b0;
      allow_drain = 1'b0;
      action_in   = '0;
      out_ready   = 1'b1;
      tick();
      tick();
      neg();
      chk_reset("reset");
      rst_n = 1'b1;
      tick();

      // single packet, release latency T+2
      push(64'hA, 1'b1, 1'b0, 1'b1, 64'h10);
      push(64'hB, 1'b0, 1'b0, 1'b1, 64'h10);
      push(64'hC, 1'b0, 1'b1, 1'b1, 64'h10);
      pulse(64'h10);
      neg();
      chk("t1_valid_t1", 64'(out_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         neg();
         chk("t1_valid_beat", 64'(out_valid), 64'd1);
      end
      tick();
      neg();
      chk("t1_valid_after", 64'(out_valid), 64'd0);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // drop
      push(64'hA, 1'b1, 1'b0, 1'b0, 64'h0);
      push(64'hB, 1'b0, 1'b0, 1'b0, 64'h0);
      push(64'hC, 1'b0, 1'b1, 1'b0, 64'h0);
      pulse(64'h1);
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("drop_no_valid", 64'(out_valid), 64'd0);
         tick();
      end
      neg();
      chk("drop_count1", 64'(drop_count), 64'd1);
      chk("drop_action", out_action, 64'h1);

      // backpressure and underrun
      pulse(64'h20);
      for (int i = 0; i < 6; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         push(64'h200 + 64'(i), i == 0, i == 5, 1'b1, 64'h20);
         for (int k = 0; k < 2; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      out_ready = 1'b1;
      wait_drain();
      chk("bp_framing", 64'(err_framing), 64'd0);

      // data FIFO full
      for (int i = 0; i < 64; i++)
         push(64'h300 + 64'(i), i == 0, i == 63, 1'b1, 64'h30);
      neg();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      pulse(64'h30);
      neg();
      chk("full_ready_t1", 64'(in_ready), 64'd0);
      tick();
      neg();
      chk("full_ready_t2", 64'(in_ready), 64'd0);
      tick();
      neg();
      chk("full_ready_t3", 64'(in_ready), 64'd1);
      wait_drain();

      // action queue overflow: fifth pulse is discarded
      chk("ovf_before", 64'(err_act_ovf), 64'd0);
      for (int i = 0; i < 5; i++)
         pulse(64'h40 + 64'(i) * 64'h10);
      neg();
      chk("ovf_flag", 64'(err_act_ovf), 64'd1);
      for (int i = 0; i < 4; i++)
         push(64'h400 + 64'(i), 1'b1, 1'b1, 1'b1,
              64'h40 + 64'(i) * 64'h10);
      wait_drain();

      // back-to-back single-beat packets
      push(64'h501, 1'b1, 1'b1, 1'b1, 64'h90);
      push(64'h502, 1'b1, 1'b1, 1'b1, 64'hA0);
      allow_drain = 1'b1;
      action_in   = 64'h90;
      tick();
      action_in = 64'hA0;
      tick();
      allow_drain = 1'b0;
      neg();
      chk("b2b_first", 64'(out_valid), 64'd1);
      tick();
      neg();
      chk("b2b_bubble", 64'(out_valid), 64'd0);
      tick();
      neg();
      chk("b2b_second", 64'(out_valid), 64'd1);
      tick();
      neg();
      chk("b2b_after", 64'(out_valid), 64'd0);
      chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

      // reset while the second beat is presented
      push(64'h600, 1'b1, 1'b0, 1'b1, 64'hB0);
      push(64'h601, 1'b0, 1'b0, 1'b0, 64'h0);
      push(64'h602, 1'b0, 1'b0, 1'b0, 64'h0);
      push(64'h603, 1'b0, 1'b1, 1'b0, 64'h0);
      pulse(64'hB0);
      tick();
      tick();
      rst_n     = 1'b0;
      out_ready = 1'b0;
      tick();
      neg();
      chk_reset("midrst");
      chk("midrst_sb", 64'(sb.size()), 64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      push(64'h700, 1'b1, 1'b0, 1'b1, 64'hC0);
      push(64'h701, 1'b0, 1'b1, 1'b1, 64'hC0);
      pulse(64'hC0);
      wait_drain();
      chk("post_rst_framing", 64'(err_framing), 64'd0);

      // packet whose first beat lacks sop
      push(64'h800, 1'b0, 1'b1, 1'b1, 64'hD0);
      pulse(64'hD0);
      wait_drain();
      neg();
      chk("framing_err", 64'(err_framing), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
